// File: rtl/cyberwar_pkg.sv
// Shared definitions for the Cyber War press sources: LFSR geometry,
// the cyber-opponent state encoding and the LFSR step function.
package cyberwar_pkg;

   localparam int LFSR_W     = 10;
   // Feedback taps, numbered 1..LFSR_W as in the usual polynomial notation.
   localparam int LFSR_TAP_A = 10;
   localparam int LFSR_TAP_B = 7;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESS   = 2'd1,
      RELEASE = 2'd2
   } cyber_state_t;

   // One Fibonacci step with XNOR feedback. XNOR makes all-zeros a legal
   // seed, so reset to zero is safe; all-ones is the unreachable lockup.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
      return {q[LFSR_W-2:0], ~(q[LFSR_TAP_A-1] ^ q[LFSR_TAP_B-1])};
   endfunction

endpackage

// File: rtl/key_conditioner.sv
// Conditions one raw human key: two-flop synchronizer, counting debounce,
// and a one-cycle pulse on each debounced press (nothing on release).
module key_conditioner #(
   parameter int DB_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic key_raw,
   output logic pulse
);

   localparam int CNT_W = 8;

   logic             sync_a;
   logic             sync_b;
   logic             db_q;
   logic             db_prev;
   logic [CNT_W-1:0] db_cnt;

   // Bring the asynchronous key into the clk domain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
      end else begin
         // NOTE: non-blocking so sync_b takes the old sync_a; blocking here
         // would collapse the two flops into one and defeat the synchronizer.
         sync_a <= key_raw;
         sync_b <= sync_a;
      end
   end

   // Flip the debounced level only after DB_CYCLES+1 consecutive differing samples.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db_q   <= 1'b0;
         db_cnt <= '0;
      end else if (sync_b == db_q) begin
         db_cnt <= '0;
      end else if (db_cnt == CNT_W'(DB_CYCLES)) begin
         db_q   <= ~db_q;
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end

   // Remember the previous debounced level for rising-edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) db_prev <= 1'b0;
      else       db_prev <= db_q;
   end

   assign pulse = db_q & ~db_prev;

endmodule

// File: rtl/press_pulse_gen.sv
// Left/right press pulse source for the playfield light chain: the human
// key on the left, the LFSR-driven cyber opponent on the right, with a
// shared enable gate that also cancels simultaneous presses.
module press_pulse_gen
   import cyberwar_pkg::*;
#(
   parameter int DB_CYCLES = 16,
   parameter int HOLDOFF   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              key_l,
   input  logic [LFSR_W-1:0] speed,
   input  logic              enable,
   output logic              press_l,
   output logic              press_r,
   output logic [LFSR_W-1:0] lfsr_q
);

   localparam int HOLD_W = 8;

   logic              raw_l;
   logic              raw_r;
   cyber_state_t      state;
   cyber_state_t      state_next;
   logic [HOLD_W-1:0] hold_cnt;
   logic [HOLD_W-1:0] hold_cnt_next;

   key_conditioner #(
      .DB_CYCLES(DB_CYCLES)
   ) u_key_l (
      .clk    (clk),
      .reset  (reset),
      .key_raw(key_l),
      .pulse  (raw_l)
   );

   // Free-running pseudo-random source; advances even while the game is paused.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr_q <= '0;
      else       lfsr_q <= lfsr_next(lfsr_q);
   end

   // Cyber player decision: press when the random draw falls below speed,
   // then sit out HOLDOFF cycles before drawing again.
   always_comb begin
      // NOTE: defaults first so every path assigns both signals; a missing
      // branch would otherwise infer a latch.
      state_next    = state;
      hold_cnt_next = hold_cnt;
      if (!enable) begin
         state_next    = IDLE;
         hold_cnt_next = '0;
      end else begin
         case (state)
            IDLE: begin
               if (lfsr_q < speed) state_next = PRESS;
            end
            PRESS: begin
               state_next    = RELEASE;
               hold_cnt_next = HOLD_W'(HOLDOFF);
            end
            RELEASE: begin
               hold_cnt_next = hold_cnt - 1'b1;
               if (hold_cnt == HOLD_W'(1)) state_next = IDLE;
            end
            default: begin
               state_next    = IDLE;
               hold_cnt_next = '0;
            end
         endcase
      end
   end

   // Register the cyber state and its holdoff counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         hold_cnt <= '0;
      end else begin
         state    <= state_next;
         hold_cnt <= hold_cnt_next;
      end
   end

   assign raw_r = (state == PRESS);

   // Both raw sources are flop outputs, so only enable and the tie cancel
   // sit between them and the pins.
   assign press_l = raw_l & enable & ~raw_r;
   assign press_r = raw_r & enable & ~raw_l;

endmodule

// File: doc/press_pulse_gen.md
# press_pulse_gen

Source of the single-cycle L/R press pulses consumed by the playfield light chain in the Cyber War tug-of-war design. Left side conditions a raw human key (synchronize, debounce, rising-edge detect). Right side is the cyber opponent: a 10-bit LFSR compared against a speed setting, paced by a press/release FSM. A shared output stage gates both sides with the game-enable input and cancels simultaneous presses.

## Interface
- DB_CYCLES, 16: consecutive stable cycles required before the debounced key changes; legal range 2..255.
- HOLDOFF, 8: cycles the cyber player spends in RELEASE after each press; legal range 1..255.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- key_l  in  1  raw human key, active-high, asynchronous to clk.
- speed  in  10  cyber aggressiveness: 0 means never press; larger values press more often.
- enable  in  1  game running; low masks all presses.
- press_l  out  1  one-cycle left press pulse.
- press_r  out  1  one-cycle right press pulse.
- lfsr_q  out  10  current LFSR value, for debug/seed display.

## Operation
- Reset values: press_l=0, press_r=0, lfsr_q=10'h000, sync flops=0, debounced key=0, debounce count=0, cyber state=IDLE, holdoff count=0.
- Key path: two-flop synchronizer → debounce → edge detect.
  - Debounce: when sync output ≠ debounced value, count increments each cycle. When the count reaches DB_CYCLES, the debounced value flips and the count clears. Any cycle where sync output = debounced value clears the count.
  - raw_l is asserted for exactly one cycle on a debounced 0→1 transition. There is no pulse on release.
- LFSR: 10-bit Fibonacci with XNOR feedback, taps 10 and 7; new bit shifts into bit 0.
  - Advances every cycle regardless of enable.
  - Period is 1023. All-ones is the lockup state and is never reached from reset.
- Cyber FSM (states IDLE, PRESS, RELEASE):
  - IDLE→PRESS when enable and lfsr_q < speed (unsigned, 10-bit). Otherwise stays in IDLE.
  - PRESS→RELEASE unconditionally; the holdoff count loads HOLDOFF.
  - RELEASE: the count decrements each cycle; RELEASE→IDLE when the count reaches 1.
  - enable low in any state forces IDLE on the next edge.
  - raw_r = (state==PRESS).
- Output stage:
  - press_l = raw_l & enable & ~raw_r.
  - press_r = raw_r & enable & ~raw_l.
  - Simultaneous raw presses produce no pulse on either side (tie cancels).
- Debounce keeps running while enable is low. A key already held when enable rises produces no pulse, because no new edge occurs.

## Timing
- Key latency: if k is the first edge sampling key_l=1 (held), press_l is high for exactly the cycle after edge k+2+DB_CYCLES.
- Key glitches: a high pulse on key_l of fewer than DB_CYCLES+1 sampled cycles never produces press_l.
- Cyber cadence: at most one press_r per HOLDOFF+2 cycles. With speed=10'h3FF, press_r fires exactly every HOLDOFF+2 cycles.
- press_r is high in the cycle after the edge where IDLE observed lfsr_q < speed.
- press_l and press_r are registered-state derived and combinationally gated by enable. Both are glitch-free relative to clk.
- Reset mid-operation: all state returns to reset values immediately. A press in flight is dropped; no pulse is emitted after reset deasserts until a new debounced edge or a new IDLE→PRESS decision.

## Structure
- Shared package cyberwar_pkg:
  - LFSR_W=10.
  - LFSR tap constants.
  - typedef enum logic [1:0] cyber_state_t {IDLE, PRESS, RELEASE}.
- Sub-module key_conditioner (params DB_CYCLES; ports clk, reset, key_raw, pulse): synchronizer, debounce and edge detect. It is reused for any future human inputs.
- Top level holds the LFSR, the cyber FSM, the holdoff counter and the output gating.

## Test plan
- Reset, then enable=1, speed=0, key_l=0 for 2000 cycles → press_l and press_r never assert. lfsr_q never equals 10'h3FF and repeats with period 1023.
- DB_CYCLES=16, enable=1, speed=0; key_l held high from edge 10 → press_l high only in cycle after edge 28. Release and re-press gives one pulse per press.
- key_l pulses of 5 and 15 cycles high → no press_l. A 20-cycle pulse → exactly one press_l.
- speed=10'h3FF, HOLDOFF=8, enable=1 → press_r every 10 cycles. Dropping enable mid-RELEASE → press_r stays 0 and FSM is in IDLE the next cycle.
- Force raw_l and raw_r coincident (align key edge with a PRESS cycle) → neither press_l nor press_r asserts in that cycle.
- Assert reset during RELEASE and during debounce count → all outputs 0 and lfsr_q=0 immediately. Normal behavior resumes after deassert.
